// File: rtl/parity_frame_rx_if.sv
// Serial-line bundle for the parity frame receiver: bit strobe and line in, word and status out.
interface parity_frame_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              bit_en;
  logic              sin;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output bit_en, sin,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  bit_en, sin,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Bit-strobed serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Delivers each word with a one-cycle valid pulse plus parity and framing error flags.
module parity_frame_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  parity_frame_rx_if.slave   bus
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                perr_q, perr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_out_q, perr_out_d;
  logic                ferr_q, ferr_d;
  logic                busy_q, busy_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and output logic; nothing advances without a bit strobe
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;

    if (bus.bit_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!bus.sin) begin
            state_d = S_DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
          end
        end
        S_DATA: begin
          shift_d[cnt_q] = bus.sin;
          acc_d          = acc_q ^ bus.sin;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          perr_d  = acc_q ^ bus.sin ^ ODD_PARITY;
          state_d = S_STOP;
        end
        S_STOP: begin
          data_d     = shift_q;
          perr_out_d = perr_q;
          ferr_d     = ~bus.sin;
          valid_d    = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_out_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;

endmodule
